// File: rtl/sc_behavior_arbiter_pkg.sv
// Shared encodings and defaults for the behavior arbiter that feeds the
// path mux state machine's BEHAVIOR and NEWSIGNAL inputs.
package sc_behavior_arbiter_pkg;

    typedef enum logic [1:0] {
        S_POS   = 2'd0,
        S_AVOID = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int DEBOUNCE_DEFAULT = 50000;
    localparam int HOLD_DEFAULT     = 25000000;

    localparam logic BEHAVIOR_POS   = 1'b1;
    localparam logic BEHAVIOR_AVOID = 1'b0;

    // Only the position-control state hands the mux to the position controller.
    function automatic logic behavior_of(input state_t s);
        return (s == S_POS) ? BEHAVIOR_POS : BEHAVIOR_AVOID;
    endfunction

endpackage

// File: rtl/sc_input_debouncer.sv
// 2-FF synchronizer plus counter debouncer for an active-low asynchronous
// input; active_out is the filtered level (1 = input asserted low).
module sc_input_debouncer
    import sc_behavior_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in_low,
    output logic active_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             active_q;
    logic             active_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle that agrees with the filtered level restarts the count, so
    // only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips it.
    always_comb begin
        active_d = active_q;
        cnt_d    = '0;
        if (~sync2_q != active_q) begin
            if (cnt_q == CNT_LAST) begin
                active_d = ~active_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_in_low;
            sync2_q  <= sync1_q;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign active_out = active_q;

endmodule

// File: rtl/sc_behavior_arbiter.sv
// Chooses position control vs obstacle avoidance (with a post-clear dwell)
// and emits a one-cycle active-low strobe for every new goal.
module sc_behavior_arbiter
    import sc_behavior_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_DEFAULT,
    parameter int CNT_W           = 25
) (
    input  logic       SC_STATEMACHINE_MUX41_CLOCK_50,
    input  logic       SC_STATEMACHINE_MUX41_RESET_InHigh,
    input  logic       SC_BEHAVIORARBITER_OBSTACLE_InLow,
    input  logic       SC_BEHAVIORARBITER_GOAL_InLow,
    output logic       SC_BEHAVIORARBITER_BEHAVIOR_Out,
    output logic       SC_BEHAVIORARBITER_NEWSIGNAL_OutLow,
    output logic [1:0] SC_BEHAVIORARBITER_STATE_OutBus
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic             obst_f;
    logic             goal_sync1_q;
    logic             goal_sync2_q;
    logic             goal_prev_q;
    logic             new_goal_n_q;
    logic             new_goal_n_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             behavior_q;
    logic             behavior_d;

    sc_input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_obstacle_debouncer (
        .clock      (SC_STATEMACHINE_MUX41_CLOCK_50),
        .reset      (SC_STATEMACHINE_MUX41_RESET_InHigh),
        .raw_in_low (SC_BEHAVIORARBITER_OBSTACLE_InLow),
        .active_out (obst_f)
    );

    assign new_goal_n_d = ~(goal_prev_q & ~goal_sync2_q);

    // A re-asserted obstacle always wins over the dwell expiring in S_HOLD.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_POS: begin
                if (obst_f) state_d = S_AVOID;
            end
            S_AVOID: begin
                if (!obst_f) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (obst_f) begin
                    state_d = S_AVOID;
                end else if (hold_cnt_q == '0) begin
                    state_d = S_POS;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d    = S_POS;
                hold_cnt_d = '0;
            end
        endcase
        behavior_d = behavior_of(state_d);
    end

    always_ff @(posedge SC_STATEMACHINE_MUX41_CLOCK_50 or posedge SC_STATEMACHINE_MUX41_RESET_InHigh) begin
        if (SC_STATEMACHINE_MUX41_RESET_InHigh) begin
            state_q      <= S_POS;
            hold_cnt_q   <= '0;
            behavior_q   <= BEHAVIOR_POS;
            goal_sync1_q <= 1'b1;
            goal_sync2_q <= 1'b1;
            goal_prev_q  <= 1'b1;
            new_goal_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            behavior_q   <= behavior_d;
            goal_sync1_q <= SC_BEHAVIORARBITER_GOAL_InLow;
            goal_sync2_q <= goal_sync1_q;
            goal_prev_q  <= goal_sync2_q;
            new_goal_n_q <= new_goal_n_d;
        end
    end

    assign SC_BEHAVIORARBITER_BEHAVIOR_Out     = behavior_q;
    assign SC_BEHAVIORARBITER_NEWSIGNAL_OutLow = new_goal_n_q;
    assign SC_BEHAVIORARBITER_STATE_OutBus     = state_q;

endmodule

// File: tb/tb_sc_behavior_arbiter.sv
// Scoreboard bench: stimulus queues the expected output changes with their
// clock-edge index, a monitor pops one entry per observed change or probe.
module tb_sc_behavior_arbiter;

    typedef struct {
        int         cyc;
        logic       beh;
        logic       nsig;
        logic [1:0] st;
        string      name;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       obst  = 1'b1;
    logic       goal  = 1'b1;
    logic       beh;
    logic       nsig;
    logic [1:0] st;

    logic       mon_en = 1'b0;
    logic       probe  = 1'b0;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    sc_behavior_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .CNT_W           (25)
    ) dut (
        .SC_STATEMACHINE_MUX41_CLOCK_50      (clk),
        .SC_STATEMACHINE_MUX41_RESET_InHigh  (rst),
        .SC_BEHAVIORARBITER_OBSTACLE_InLow   (obst),
        .SC_BEHAVIORARBITER_GOAL_InLow       (goal),
        .SC_BEHAVIORARBITER_BEHAVIOR_Out     (beh),
        .SC_BEHAVIORARBITER_NEWSIGNAL_OutLow (nsig),
        .SC_BEHAVIORARBITER_STATE_OutBus     (st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic next_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic obst_v, input logic goal_v);
        obst = obst_v;
        goal = goal_v;
    endtask

    task automatic expect_event(input int c, input logic b, input logic n,
                                input logic [1:0] s, input string nm);
        exp_t e;
        e.cyc  = c;
        e.beh  = b;
        e.nsig = n;
        e.st   = s;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic request_probe(input logic b, input logic n,
                                 input logic [1:0] s, input string nm);
        expect_event(cyc, b, n, s, nm);
        probe = ~probe;
    endtask

    task automatic check_output(input logic [3:0] cur);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_change: got beh=%b nsig=%b state=%0d at cycle %0d, no change expected",
                     cur[3], cur[2], cur[1:0], cyc);
        end else begin
            e = exp_q.pop_front();
            if (cur !== {e.beh, e.nsig, e.st} || cyc != e.cyc) begin
                errors++;
                $display("[TB] FAIL %s: got beh=%b nsig=%b state=%0d at cycle %0d, expected beh=%b nsig=%b state=%0d at cycle %0d",
                         e.name, cur[3], cur[2], cur[1:0], cyc, e.beh, e.nsig, e.st, e.cyc);
            end
        end
    endtask

    // Monitor: every output change (or explicit probe) consumes one expectation.
    initial begin : monitor
        logic [3:0] cur;
        logic [3:0] last;
        logic       probe_last;
        wait (mon_en);
        last       = {beh, nsig, st};
        probe_last = probe;
        forever begin
            @(beh or nsig or st or probe);
            #1;
            cur = {beh, nsig, st};
            if (cur !== last || probe !== probe_last) begin
                check_output(cur);
                last       = cur;
                probe_last = probe;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int e;
        int r;
        int g;
        exp_t left;

        apply_stimulus(1'b1, 1'b1);
        next_edge(3);
        mon_en = 1'b1;
        next_edge(1);
        request_probe(1'b1, 1'b1, 2'd0, "reset_state");
        next_edge(2);
        rst = 1'b0;

        next_edge(100);
        request_probe(1'b1, 1'b1, 2'd0, "idle_100_cycles");

        // Three-cycle obstacle glitch must be swallowed by the debouncer.
        next_edge(2);
        apply_stimulus(1'b0, 1'b1);
        next_edge(3);
        apply_stimulus(1'b1, 1'b1);
        next_edge(20);
        request_probe(1'b1, 1'b1, 2'd0, "glitch_ignored");

        next_edge(2);
        e = cyc;
        apply_stimulus(1'b0, 1'b1);
        expect_event(e + 7, 1'b0, 1'b1, 2'd1, "enter_avoid");
        next_edge(12);
        r = cyc;
        apply_stimulus(1'b1, 1'b1);
        expect_event(r + 7, 1'b0, 1'b1, 2'd2, "enter_hold");
        expect_event(r + 15, 1'b1, 1'b1, 2'd0, "hold_dwell_done");
        next_edge(20);

        // Re-assert so the debounced flag lands exactly when the hold counter is 0.
        e = cyc;
        apply_stimulus(1'b0, 1'b1);
        expect_event(e + 7, 1'b0, 1'b1, 2'd1, "s4_enter_avoid");
        next_edge(12);
        r = cyc;
        apply_stimulus(1'b1, 1'b1);
        expect_event(r + 7, 1'b0, 1'b1, 2'd2, "s4_enter_hold");
        next_edge(8);
        apply_stimulus(1'b0, 1'b1);
        expect_event(r + 15, 1'b0, 1'b1, 2'd1, "s4_reassert_at_zero");
        next_edge(12);
        r = cyc;
        apply_stimulus(1'b1, 1'b1);
        expect_event(r + 7, 1'b0, 1'b1, 2'd2, "s4_second_hold");
        expect_event(r + 15, 1'b1, 1'b1, 2'd0, "s4_reload_dwell");
        next_edge(20);

        e = cyc;
        apply_stimulus(1'b1, 1'b0);
        expect_event(e + 3, 1'b1, 1'b0, 2'd0, "goal_pulse_low");
        expect_event(e + 4, 1'b1, 1'b1, 2'd0, "goal_pulse_high");
        next_edge(20);
        apply_stimulus(1'b1, 1'b1);
        next_edge(5);
        for (int i = 0; i < 3; i++) begin
            g = cyc;
            apply_stimulus(1'b1, 1'b0);
            expect_event(g + 3, 1'b1, 1'b0, 2'd0, $sformatf("goal%0d_low", i));
            expect_event(g + 4, 1'b1, 1'b1, 2'd0, $sformatf("goal%0d_high", i));
            next_edge(4);
            apply_stimulus(1'b1, 1'b1);
            next_edge(4);
        end

        // Reset mid-dwell (hold counter = 5) must act between clock edges.
        e = cyc;
        apply_stimulus(1'b0, 1'b1);
        expect_event(e + 7, 1'b0, 1'b1, 2'd1, "s6_enter_avoid");
        next_edge(10);
        r = cyc;
        apply_stimulus(1'b1, 1'b1);
        expect_event(r + 7, 1'b0, 1'b1, 2'd2, "s6_enter_hold");
        next_edge(9);
        #3;
        expect_event(cyc, 1'b1, 1'b1, 2'd0, "async_reset_mid_hold");
        rst = 1'b1;
        next_edge(2);
        rst = 1'b0;
        next_edge(30);
        request_probe(1'b1, 1'b1, 2'd0, "stay_pos_after_reset");

        next_edge(3);
        while (exp_q.size() > 0) begin
            left = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: event never observed, expected beh=%b nsig=%b state=%0d at cycle %0d",
                     left.name, left.beh, left.nsig, left.st, left.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_behavior_arbiter.md
# sc_behavior_arbiter

- Generates the behavior-select and new-goal strobes consumed by the robot's path mux state machine.
- Filters a raw, active-low obstacle comparator input through a synchronizer and debouncer, then decides between position control and obstacle avoidance.
- Holds avoidance for a programmable dwell after the obstacle clears.
- Sits between the sensor front-end and the mux-select controller, and drives that controller's BEHAVIOR and NEWSIGNAL inputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept an obstacle-input change (1 ms at 50 MHz); must be ≥1.
- HOLD_CYCLES, 25000000, cycles avoidance is held after the obstacle clears (0.5 s); must be ≥1.
- CNT_W, 25, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- SC_STATEMACHINE_MUX41_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINE_MUX41_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_BEHAVIORARBITER_OBSTACLE_InLow  in  1  raw obstacle comparator, asynchronous; 0 = obstacle present.
- SC_BEHAVIORARBITER_GOAL_InLow  in  1  asynchronous goal-load signal; a falling edge means a new goal.
- SC_BEHAVIORARBITER_BEHAVIOR_Out  out  1  1 = position controller, 0 = avoid obstacles.
- SC_BEHAVIORARBITER_NEWSIGNAL_OutLow  out  1  one-cycle low pulse per new goal.
- SC_BEHAVIORARBITER_STATE_OutBus  out  2  current state, for debug.

## Operation
Input conditioning:
- Each asynchronous input passes through a 2-FF synchronizer. Reset value is 1 (inactive).
- Obstacle debouncer:
  - Holds a filtered flag `obst_f` (1 = obstacle) and a counter.
  - Counter clears whenever the synchronized value matches `obst_f`.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, `obst_f` toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Goal edge detect: a registered 1→0 transition of the synchronized goal signal drives NEWSIGNAL_OutLow low for exactly one cycle. Back-to-back edges are impossible after synchronization.

FSM states (encoding lives in the package):
- S_POS = 2'd0
- S_AVOID = 2'd1
- S_HOLD = 2'd2
- 2'd3 is illegal and recovers to S_POS.

Transitions, evaluated on each clock edge:
- S_POS: `obst_f` = 1 → S_AVOID; otherwise stay.
- S_AVOID: `obst_f` = 0 → S_HOLD, loading the hold counter with HOLD_CYCLES-1; otherwise stay.
- S_HOLD:
  - `obst_f` = 1 → S_AVOID. This has priority, including in the cycle the counter is 0.
  - Else, counter = 0 → S_POS.
  - Else, decrement the counter.

Outputs:
- BEHAVIOR_Out = 1 in S_POS; 0 in S_AVOID and S_HOLD. It is decoded directly from the state register, with no combinational path from inputs.
- STATE_OutBus = state register.
- New-goal events do not change FSM state; goal and obstacle paths are independent.

Reset (asserted at any time, including mid-HOLD or mid-debounce) asynchronously forces:
- state to S_POS
- BEHAVIOR_Out to 1
- NEWSIGNAL_OutLow to 1
- STATE_OutBus to 0
- `obst_f` to 0
- all counters to 0
- synchronizers to 1

After reset deasserts, the block restarts from clean state; no partial debounce count is retained.

## Timing
- Obstacle asserted (raw 0) and held stable, first sampled at edge 0:
  - synchronized value appears at edge 2
  - `obst_f` sets at edge 1+DEBOUNCE_CYCLES+1
  - state and BEHAVIOR_Out change after edge DEBOUNCE_CYCLES+3
- Obstacle release has the same latency to entering S_HOLD.
- S_HOLD dwell: with no re-assertion, S_POS is reached exactly HOLD_CYCLES cycles after entering S_HOLD.
- Goal falling edge sampled at edge 0: NEWSIGNAL_OutLow is low during the cycle after edge 3 only.
- Throughput: one decision per clock. There is no handshake; outputs are level or strobe signals.

## Structure
Package `sc_behavior_arbiter_pkg` contains:
- state encodings S_POS, S_AVOID, S_HOLD
- default constants DEBOUNCE_DEFAULT = 50000, HOLD_DEFAULT = 25000000
- BEHAVIOR_POS = 1'b1, BEHAVIOR_AVOID = 1'b0

Sub-module `sc_input_debouncer` (parameter DEBOUNCE_CYCLES, CNT_W) implements the 2-FF synchronizer plus the debounce counter, with a filtered-level output. It is instantiated once for the obstacle input. The goal path uses a bare synchronizer and edge detector inside the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
1. Reset, then idle inputs high → BEHAVIOR_Out=1, NEWSIGNAL_OutLow=1, STATE_OutBus=0, held for 100 cycles.
2. Obstacle low for 3 cycles, then high → no state change; BEHAVIOR_Out stays 1.
3. Obstacle low held → BEHAVIOR_Out falls exactly 7 cycles after first sampling edge, STATE_OutBus=1. Release → STATE_OutBus=2 after a further 7 cycles, then BEHAVIOR_Out=1 and STATE_OutBus=0 exactly 8 cycles later.
4. Obstacle re-asserted (debounced) while in S_HOLD with counter at 0 → next state S_AVOID, BEHAVIOR_Out stays 0, hold counter reloaded on the next release.
5. Goal falls 1→0 and stays low 20 cycles → exactly one low cycle on NEWSIGNAL_OutLow, 3 cycles after sampling. Three separate goal edges → exactly three pulses.
6. Reset asserted mid-S_HOLD (counter=5) → outputs return to reset values immediately, without waiting for a clock edge. After release with obstacle high, the block stays in S_POS.
